serial_add: RTL

SERIAL_ADD -- requirements
Module: serial_add

---
 rtl/serial_add.sv | 94 +++++++++
 1 files changed

// File: rtl/serial_add.sv
// Bit-serial adder that rebuilds the minuend from a subtractor's diff and b.
// Processes one bit per clock, LSB first, with a single carry flip-flop.
module serial_add #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] diff,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic             cf;

  logic [1:0]       bit_sum;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // Full-adder slice and the result register after shifting in this bit.
  always_comb begin
    bit_sum = {1'b0, sh_d[0]} + {1'b0, sh_b[0]} + {1'b0, cf};
    res_next = sh_r >> 1;
    res_next[WIDTH-1] = bit_sum[0];
    last = (cnt == CW'(WIDTH - 1));
  end

  // Sequencer: accept in IDLE, one bit per edge in ADD, one-cycle DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh_d  <= '0;
      sh_b  <= '0;
      sh_r  <= '0;
      cf    <= 1'b0;
      a     <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_d  <= diff;
            sh_b  <= b;
            sh_r  <= '0;
            cf    <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          sh_r <= res_next;
          cf   <= bit_sum[1];
          sh_d <= sh_d >> 1;
          sh_b <= sh_b >> 1;
          if (last) begin
            a     <= res_next;
            carry <= bit_sum[1];
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from state so reset clears them immediately.
  always_comb begin
    busy = (state == ADD) || (state == DONE);
    done = (state == DONE);
  end

endmodule
